// File: rtl/motoro3_gate_deadtime.sv
// rtl/motoro3_gate_deadtime.sv - half-bridge gate driver with dead time, min pulse and fault latch
// Turns one pwm request into complementary gateH/gateL drives that are never both on.
module motoro3_gate_deadtime #(
    parameter int DT_W = 8,
    parameter int MP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwmActive1,
    input  logic            pwm,
    input  logic            m3r_syncRect,
    input  logic [DT_W-1:0] m3r_deadTime,
    input  logic [MP_W-1:0] m3r_minPulse,
    input  logic            faultIn,
    input  logic            faultClr,
    output logic            gateH,
    output logic            gateL,
    output logic            faultSticky,
    output logic [7:0]      stretchCnt
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DT_H,
        ST_ON_H,
        ST_DT_L,
        ST_ON_L,
        ST_FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            pwm_r;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_nxt;
    logic [MP_W-1:0] min_cnt;
    logic [MP_W-1:0] min_nxt;
    logic            stretched;
    logic            stretched_nxt;
    logic            stretch_inc;
    logic [DT_W-1:0] dt_load;
    logic [MP_W-1:0] mp_load;

    // A programmed value of zero behaves like one cycle.
    assign dt_load = (m3r_deadTime == '0) ? '0 : m3r_deadTime - DT_W'(1);
    assign mp_load = (m3r_minPulse == '0) ? '0 : m3r_minPulse - MP_W'(1);

    always_comb begin
        state_nxt     = state;
        dt_nxt        = dt_cnt;
        min_nxt       = min_cnt;
        stretched_nxt = stretched;
        stretch_inc   = 1'b0;
        if (faultIn) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (faultClr) state_nxt = ST_OFF;
        end else if (!pwmActive1) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwm_r) begin
                        state_nxt = ST_DT_H;
                        dt_nxt    = dt_load;
                    end else if (m3r_syncRect) begin
                        state_nxt = ST_DT_L;
                        dt_nxt    = dt_load;
                    end
                end
                ST_DT_H: begin
                    if (!pwm_r) begin
                        state_nxt = ST_OFF;
                    end else if (dt_cnt == '0) begin
                        state_nxt     = ST_ON_H;
                        min_nxt       = mp_load;
                        stretched_nxt = 1'b0;
                    end else begin
                        dt_nxt = dt_cnt - DT_W'(1);
                    end
                end
                ST_DT_L: begin
                    if (pwm_r || !m3r_syncRect) begin
                        state_nxt = ST_OFF;
                    end else if (dt_cnt == '0) begin
                        state_nxt = ST_ON_L;
                        min_nxt   = mp_load;
                    end else begin
                        dt_nxt = dt_cnt - DT_W'(1);
                    end
                end
                ST_ON_H: begin
                    if (min_cnt != '0) begin
                        min_nxt = min_cnt - MP_W'(1);
                        // Count each held-on pulse once, on the first early release.
                        if (!pwm_r && !stretched) begin
                            stretch_inc   = 1'b1;
                            stretched_nxt = 1'b1;
                        end
                    end else if (!pwm_r) begin
                        if (m3r_syncRect) begin
                            state_nxt = ST_DT_L;
                            dt_nxt    = dt_load;
                        end else begin
                            state_nxt = ST_OFF;
                        end
                    end
                end
                ST_ON_L: begin
                    if (!m3r_syncRect) begin
                        state_nxt = ST_OFF;
                    end else if (min_cnt != '0) begin
                        min_nxt = min_cnt - MP_W'(1);
                    end else if (pwm_r) begin
                        state_nxt = ST_DT_H;
                        dt_nxt    = dt_load;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OFF;
            pwm_r       <= 1'b0;
            dt_cnt      <= '0;
            min_cnt     <= '0;
            stretched   <= 1'b0;
            gateH       <= 1'b0;
            gateL       <= 1'b0;
            faultSticky <= 1'b0;
            stretchCnt  <= 8'd0;
        end else begin
            state       <= state_nxt;
            pwm_r       <= pwm;
            dt_cnt      <= dt_nxt;
            min_cnt     <= min_nxt;
            stretched   <= stretched_nxt;
            gateH       <= (state_nxt == ST_ON_H);
            gateL       <= (state_nxt == ST_ON_L);
            faultSticky <= (state_nxt == ST_FAULT);
            if (stretch_inc && stretchCnt != 8'hFF) stretchCnt <= stretchCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_motoro3_gate_deadtime.sv
// tb/tb_motoro3_gate_deadtime.sv - directed self-checking bench for motoro3_gate_deadtime
module tb_motoro3_gate_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwmActive1;
    logic       pwm;
    logic       m3r_syncRect;
    logic [7:0] m3r_deadTime;
    logic [7:0] m3r_minPulse;
    logic       faultIn;
    logic       faultClr;
    logic       gateH;
    logic       gateL;
    logic       faultSticky;
    logic [7:0] stretchCnt;

    int errors = 0;
    int checks = 0;

    int h_run = 0, l_run = 0, gap_run = 0, last_on = 0;
    int last_h = 0, last_l = 0, gap_after_h = 0, gap_after_l = 0;
    int overlap_cnt = 0;

    motoro3_gate_deadtime #(.DT_W(8), .MP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwmActive1   (pwmActive1),
        .pwm          (pwm),
        .m3r_syncRect (m3r_syncRect),
        .m3r_deadTime (m3r_deadTime),
        .m3r_minPulse (m3r_minPulse),
        .faultIn      (faultIn),
        .faultClr     (faultClr),
        .gateH        (gateH),
        .gateL        (gateL),
        .faultSticky  (faultSticky),
        .stretchCnt   (stretchCnt)
    );

    always #50 clk = ~clk;

    // Run-length monitor of gate pulses and both-off gaps.
    always @(negedge clk) begin
        if (gateH === 1'b1 && gateL === 1'b1) overlap_cnt++;
        if (gateH === 1'b1) h_run++;
        else if (h_run != 0) begin last_h = h_run; h_run = 0; last_on = 1; end
        if (gateL === 1'b1) l_run++;
        else if (l_run != 0) begin last_l = l_run; l_run = 0; last_on = 2; end
        if (gateH === 1'b0 && gateL === 1'b0) gap_run++;
        else if (gap_run != 0) begin
            if (last_on == 1) gap_after_h = gap_run;
            else if (last_on == 2) gap_after_l = gap_run;
            gap_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int any_l;
        rst = 1'b1; pwm = 1'b1; pwmActive1 = 1'b1; m3r_syncRect = 1'b0;
        m3r_deadTime = 8'd4; m3r_minPulse = 8'd1; faultIn = 1'b0; faultClr = 1'b0;
        tick(3);
        check("rst_gateH", 32'(gateH), 32'd0);
        check("rst_gateL", 32'(gateL), 32'd0);
        check("rst_stretch", 32'(stretchCnt), 32'd0);
        check("rst_fault", 32'(faultSticky), 32'd0);

        // Dead time D=4, square wave 20/20
        rst = 1'b0; pwm = 1'b0; m3r_syncRect = 1'b1;
        tick(10);
        for (int p = 0; p < 4; p++) begin
            pwm = 1'b1; tick(20);
            pwm = 1'b0; tick(20);
        end
        check("d4_h_len", 32'(last_h), 32'd16);
        check("d4_l_len", 32'(last_l), 32'd16);
        check("d4_gap_hl", 32'(gap_after_h), 32'd4);
        check("d4_gap_lh", 32'(gap_after_l), 32'd4);

        // Dead time D=0 behaves as one cycle
        rst = 1'b1; tick(2); rst = 1'b0;
        m3r_deadTime = 8'd0;
        tick(10);
        for (int p = 0; p < 4; p++) begin
            pwm = 1'b1; tick(20);
            pwm = 1'b0; tick(20);
        end
        check("d0_h_len", 32'(last_h), 32'd19);
        check("d0_l_len", 32'(last_l), 32'd19);
        check("d0_gap_hl", 32'(gap_after_h), 32'd1);
        check("d0_gap_lh", 32'(gap_after_l), 32'd1);

        // Minimum pulse D=2, M=10
        rst = 1'b1; tick(2); rst = 1'b0;
        m3r_deadTime = 8'd2; m3r_minPulse = 8'd10; m3r_syncRect = 1'b0; pwm = 1'b0;
        tick(3);
        pwm = 1'b1;
        tick(3);
        check("lat_before", 32'(gateH), 32'd0);
        tick(1);
        check("lat_on", 32'(gateH), 32'd1);
        pwm = 1'b0;
        tick(16);
        check("mp_h_len", 32'(last_h), 32'd10);
        check("mp_stretch1", 32'(stretchCnt), 32'd1);
        for (int p = 0; p < 254; p++) begin
            pwm = 1'b1; tick(3);
            pwm = 1'b0; tick(17);
        end
        check("mp_h_len3", 32'(last_h), 32'd10);
        check("mp_stretch255", 32'(stretchCnt), 32'd255);
        for (int p = 0; p < 5; p++) begin
            pwm = 1'b1; tick(3);
            pwm = 1'b0; tick(17);
        end
        check("mp_saturate", 32'(stretchCnt), 32'd255);

        // Fault latch
        m3r_deadTime = 8'd3; m3r_minPulse = 8'd1; pwm = 1'b1;
        tick(12);
        check("flt_pre_on", 32'(gateH), 32'd1);
        faultIn = 1'b1; tick(1);
        check("flt_gateH_off", 32'(gateH), 32'd0);
        check("flt_sticky", 32'(faultSticky), 32'd1);
        faultClr = 1'b1; tick(1); faultClr = 1'b0;
        check("flt_clr_ignored", 32'(faultSticky), 32'd1);
        faultIn = 1'b0; tick(2);
        check("flt_hold", 32'(faultSticky), 32'd1);
        check("flt_hold_gateH", 32'(gateH), 32'd0);
        faultClr = 1'b1; tick(1); faultClr = 1'b0;
        check("flt_cleared", 32'(faultSticky), 32'd0);
        tick(3);
        check("flt_dt_wait", 32'(gateH), 32'd0);
        tick(1);
        check("flt_resume", 32'(gateH), 32'd1);
        check("flt_keep_stretch", 32'(stretchCnt), 32'd255);

        // Enable and sync-rect control
        pwm = 1'b0; m3r_syncRect = 1'b1; m3r_deadTime = 8'd2; m3r_minPulse = 8'd5;
        tick(8);
        check("en_pre_L", 32'(gateL), 32'd1);
        pwmActive1 = 1'b0; tick(1);
        check("en_off_L", 32'(gateL), 32'd0);
        tick(3);
        check("en_hold_L", 32'(gateL), 32'd0);
        check("en_hold_H", 32'(gateH), 32'd0);
        pwmActive1 = 1'b1;
        tick(3);
        check("sr_on_L", 32'(gateL), 32'd1);
        m3r_syncRect = 1'b0; tick(1);
        check("sr_off_L", 32'(gateL), 32'd0);
        any_l = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (gateL !== 1'b0) any_l++;
        end
        check("sr_idle_L", 32'(any_l), 32'd0);
        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
